// File: rtl/uart_reg_master.sv
// Host-side UART register-access initiator: serialises read/write requests into command
// bytes and collects read responses. Define UART_MASTER_WVERIFY_EN to read back each write.

module uart_tx #(
    parameter int unsigned BIT_RATE = 9600,
    parameter int unsigned CLK_HZ   = 100000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy
);
    localparam int unsigned CyclesPerBit = CLK_HZ / BIT_RATE;
    localparam int unsigned CycW = $clog2(CyclesPerBit) + 1;
    localparam logic [CycW-1:0] CycLast = CycW'(CyclesPerBit - 1);

    logic            busy_q;
    logic            txd_q;
    logic [8:0]      shreg_q;
    logic [3:0]      bit_q;
    logic [CycW-1:0] cyc_q;

    // bit_q 0 is the start bit, 1..8 data (LSB first), 9 the stop bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
            shreg_q <= '1;
            bit_q   <= 4'd0;
            cyc_q   <= '0;
        end else if (!busy_q) begin
            if (tx_en) begin
                busy_q  <= 1'b1;
                txd_q   <= 1'b0;
                shreg_q <= {1'b1, tx_data};
                bit_q   <= 4'd0;
                cyc_q   <= '0;
            end
        end else if (cyc_q == CycLast) begin
            cyc_q <= '0;
            if (bit_q == 4'd9) begin
                busy_q <= 1'b0;
            end else begin
                txd_q   <= shreg_q[0];
                shreg_q <= {1'b1, shreg_q[8:1]};
                bit_q   <= bit_q + 4'd1;
            end
        end else begin
            cyc_q <= cyc_q + CycW'(1);
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
endmodule

module uart_rx #(
    parameter int unsigned BIT_RATE = 9600,
    parameter int unsigned CLK_HZ   = 100000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       recv_en,
    output logic       recv_valid,
    output logic       recv_break,
    output logic [7:0] recv_data
);
    localparam int unsigned CyclesPerBit = CLK_HZ / BIT_RATE;
    localparam int unsigned CycW = $clog2(CyclesPerBit) + 1;
    localparam logic [CycW-1:0] CycLast = CycW'(CyclesPerBit - 1);
    localparam logic [CycW-1:0] CycHalf = CycW'(CyclesPerBit / 2 - 1);

    logic [1:0]      sync_q;
    logic            prev_q;
    logic            active_q;
    logic            hold_q;
    logic [CycW-1:0] cyc_q;
    logic [3:0]      bit_q;
    logic [7:0]      shreg_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            break_q;
    logic            rx_s;

    assign rx_s = sync_q[1];

    // After a break or framing error, wait for the line to go high before hunting again
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= 2'b11;
            prev_q   <= 1'b1;
            active_q <= 1'b0;
            hold_q   <= 1'b0;
            cyc_q    <= '0;
            bit_q    <= 4'd0;
            shreg_q  <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            break_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            prev_q  <= rx_s;
            valid_q <= 1'b0;
            break_q <= 1'b0;
            if (hold_q) begin
                if (rx_s) hold_q <= 1'b0;
            end else if (!active_q) begin
                if (prev_q && !rx_s) begin
                    active_q <= 1'b1;
                    cyc_q    <= '0;
                    bit_q    <= 4'd0;
                end
            end else if (cyc_q == ((bit_q == 4'd0) ? CycHalf : CycLast)) begin
                cyc_q <= '0;
                if (bit_q == 4'd0) begin
                    if (rx_s) active_q <= 1'b0;
                    else      bit_q    <= 4'd1;
                end else if (bit_q != 4'd9) begin
                    shreg_q <= {rx_s, shreg_q[7:1]};
                    bit_q   <= bit_q + 4'd1;
                end else begin
                    active_q <= 1'b0;
                    if (rx_s) begin
                        data_q  <= shreg_q;
                        valid_q <= 1'b1;
                    end else begin
                        hold_q  <= 1'b1;
                        break_q <= (shreg_q == 8'h00);
                    end
                end
            end else begin
                cyc_q <= cyc_q + CycW'(1);
            end
        end
    end

    assign recv_valid = valid_q & recv_en;
    assign recv_break = break_q & recv_en;
    assign recv_data  = data_q;
endmodule

module uart_reg_master #(
    parameter int unsigned BIT_RATE       = 9600,
    parameter int unsigned CLK_HZ         = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    input  logic       uart_rxd,
    output logic       uart_txd
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] OpWrite = 3'b010;
    localparam logic [2:0] OpRead  = 3'b011;

    typedef enum logic [2:0] {StIdle, StCmd, StCmdW, StData, StDataW, StRsp, StDone} state_e;

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            skip_q, skip_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            error_q, error_d;

    logic            tx_en, tx_busy;
    logic [7:0]      tx_data;
    logic            recv_en, recv_valid, recv_break;
    logic [7:0]      recv_data;
    logic            rd_phase;
    logic            mismatch;

`ifdef UART_MASTER_WVERIFY_EN
    logic verify_q, verify_d;
    assign rd_phase = !write_q || verify_q;
    assign mismatch = verify_q && (recv_data != wdata_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) verify_q <= 1'b0;
        else         verify_q <= verify_d;
    end
`else
    assign rd_phase = !write_q;
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= 4'h0;
            wdata_q <= 8'h00;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 8'h00;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        skip_d  = 1'b0;
        rdata_d = rdata_q;
        error_d = error_q;
        tx_en   = 1'b0;
        tx_data = {(rd_phase ? OpRead : OpWrite), 1'b0, addr_q};
        recv_en = 1'b0;
`ifdef UART_MASTER_WVERIFY_EN
        verify_d = verify_q;
`endif
        // Saturating wait counter, cleared whenever we are not awaiting a response
        cnt_d = '0;
        if (state_q == StRsp) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = StCmd;
`ifdef UART_MASTER_WVERIFY_EN
                    verify_d = 1'b0;
`endif
                end
            end
            StCmd: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    skip_d  = 1'b1;
                    state_d = StCmdW;
                end
            end
            StCmdW: begin
                if (!skip_q && !tx_busy) state_d = rd_phase ? StRsp : StData;
            end
            StData: begin
                tx_data = wdata_q;
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    skip_d  = 1'b1;
                    state_d = StDataW;
                end
            end
            StDataW: begin
                if (!skip_q && !tx_busy) begin
`ifdef UART_MASTER_WVERIFY_EN
                    verify_d = 1'b1;
                    state_d  = StCmd;
`else
                    rdata_d = 8'h00;
                    error_d = 1'b0;
                    state_d = StDone;
`endif
                end
            end
            StRsp: begin
                recv_en = 1'b1;
                if (recv_valid) begin
                    rdata_d = recv_data;
                    error_d = mismatch;
                    state_d = StDone;
                end else if (recv_break || cnt_q == CntLast) begin
                    rdata_d = 8'h00;
                    error_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

    uart_tx #(
        .BIT_RATE(BIT_RATE),
        .CLK_HZ  (CLK_HZ)
    ) u_tx (
        .clk    (clk),
        .resetn (resetn),
        .tx_en  (tx_en),
        .tx_data(tx_data),
        .txd    (uart_txd),
        .tx_busy(tx_busy)
    );

    uart_rx #(
        .BIT_RATE(BIT_RATE),
        .CLK_HZ  (CLK_HZ)
    ) u_rx (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (uart_rxd),
        .recv_en   (recv_en),
        .recv_valid(recv_valid),
        .recv_break(recv_break),
        .recv_data (recv_data)
    );
endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: decodes frames on uart_txd, plays a register target
// on uart_rxd, and checks responses and timing with immediate assertions.

module tb_uart_reg_master;
    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_error;
    logic [7:0] rsp_rdata;
    logic       uart_rxd, uart_txd;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    logic [7:0] tx_q[$];
    int tx_start[$];

    uart_reg_master #(
        .BIT_RATE      (100000),
        .CLK_HZ        (1000000),
        .TIMEOUT_CYCLES(400)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (resetn && rsp_valid) rsp_cnt <= rsp_cnt + 1;

    // Frame decoder: 10 clocks per bit, sampled mid-bit
    initial begin
        logic prev;
        logic [7:0] b;
        int st;
        prev = 1'b1;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (prev && !uart_txd && resetn) begin
                st = cyc;
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (10) @(negedge clk);
                tx_q.push_back(b);
                tx_start.push_back(st);
            end
            prev = uart_txd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame_at(input int i);
        return (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic int start_at(input int i);
        return (i < tx_start.size()) ? tx_start[i] : -100000;
    endfunction

    task automatic clear_frames();
        tx_q.delete();
        tx_start.delete();
    endtask

    task automatic do_req(input logic wr, input logic [3:0] a, input logic [7:0] d);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (tx_q.size() < n && k < 1500) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'h0, tx_q.size() >= n}, 32'h1);
    endtask

    task automatic wait_rsp(input int limit, output bit found, output logic [7:0] rd,
                            output logic er, output int at, output bit rdy);
        found = 1'b0;
        rdy   = 1'b0;
        rd    = 8'h00;
        er    = 1'b0;
        at    = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                rd    = rsp_rdata;
                er    = rsp_error;
                at    = cyc;
            end else if (req_ready) begin
                rdy = 1'b1;
            end
        end
    endtask

    task automatic bit_wait();
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Start bit and data; returns with the line high at the start of the stop bit
    task automatic send_byte(input logic [7:0] b);
        uart_rxd = 1'b0;
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            bit_wait();
        end
        uart_rxd = 1'b1;
    endtask

    initial begin
        bit found, rdy;
        logic [7:0] rd;
        logic er;
        int at, snap;

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        uart_rxd  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
        check("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
        check("rst_txd", {31'h0, uart_txd}, 32'h1);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 1: write addr 3 <- 0xA5
        clear_frames();
        snap = rsp_cnt;
        do_req(1'b1, 4'h3, 8'hA5);
`ifdef UART_MASTER_WVERIFY_EN
        wait_frames(3, "t1_frames");
        repeat (15) @(posedge clk);
        #1 send_byte(8'hA5);
        wait_rsp(300, found, rd, er, at, rdy);
        check("t1_verify_cmd", frame_at(2), 32'h63);
        check("t1_rdata", {24'h0, rd}, 32'hA5);
`else
        wait_rsp(600, found, rd, er, at, rdy);
        check("t1_rdata", {24'h0, rd}, 32'h00);
`endif
        check("t1_found", {31'h0, found}, 32'h1);
        check("t1_error", {31'h0, er}, 32'h0);
        check("t1_cmd", frame_at(0), 32'h43);
        check("t1_data", frame_at(1), 32'hA5);
        repeat (20) @(posedge clk);
        check("t1_rsp_count", rsp_cnt - snap, 32'h1);
        #1;

        // 2: read addr 5, target replies 0x3C
        clear_frames();
        do_req(1'b0, 4'h5, 8'h00);
        wait_frames(1, "t2_frames");
        repeat (15) @(posedge clk);
        #1 send_byte(8'h3C);
        wait_rsp(200, found, rd, er, at, rdy);
        check("t2_cmd", frame_at(0), 32'h65);
        check("t2_found", {31'h0, found}, 32'h1);
        check("t2_rdata", {24'h0, rd}, 32'h3C);
        check("t2_error", {31'h0, er}, 32'h0);
        repeat (20) @(posedge clk);
        #1;

        // 3: read addr 2, no reply; 100-cycle frame + 1 turnaround + 400 timeout
        clear_frames();
        do_req(1'b0, 4'h2, 8'h00);
        wait_rsp(1000, found, rd, er, at, rdy);
        check("t3_cmd", frame_at(0), 32'h62);
        check("t3_found", {31'h0, found}, 32'h1);
        check("t3_latency", at - start_at(0), 32'd501);
        check("t3_error", {31'h0, er}, 32'h1);
        check("t3_rdata", {24'h0, rd}, 32'h0);
        repeat (5) @(posedge clk);
        #1;

        // 4: read addr 1, target answers with a break
        clear_frames();
        do_req(1'b0, 4'h1, 8'h00);
        wait_frames(1, "t4_frames");
        repeat (15) @(posedge clk);
        #1 uart_rxd = 1'b0;
        wait_rsp(300, found, rd, er, at, rdy);
        check("t4_cmd", frame_at(0), 32'h61);
        check("t4_found", {31'h0, found}, 32'h1);
        check("t4_error", {31'h0, er}, 32'h1);
        @(negedge clk);
        check("t4_ready_next", {31'h0, req_ready}, 32'h1);
        repeat (40) @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (30) @(posedge clk);
        #1;

`ifndef UART_MASTER_WVERIFY_EN
        // 5: back-to-back write 0 <- 0x11 then read 7 with req_valid held
        clear_frames();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'h0;
        req_wdata = 8'h11;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        req_addr  = 4'h7;
        req_wdata = 8'hEE;
        wait_rsp(600, found, rd, er, at, rdy);
        check("t5_w_found", {31'h0, found}, 32'h1);
        check("t5_w_ready_low", {31'h0, rdy}, 32'h0);
        check("t5_w_error", {31'h0, er}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("t5_ready_after_done", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_frames(3, "t5_frames");
        repeat (15) @(posedge clk);
        #1 send_byte(8'h99);
        wait_rsp(200, found, rd, er, at, rdy);
        check("t5_r_found", {31'h0, found}, 32'h1);
        check("t5_r_ready_low", {31'h0, rdy}, 32'h0);
        check("t5_r_rdata", {24'h0, rd}, 32'h99);
        check("t5_f0", frame_at(0), 32'h40);
        check("t5_f1", frame_at(1), 32'h11);
        check("t5_f2", frame_at(2), 32'h67);
        check("t5_gap_cmd_data", start_at(1) - start_at(0), 32'd102);
        check("t5_gap_data_cmd", start_at(2) - start_at(1), 32'd104);
        repeat (20) @(posedge clk);
        #1;
`endif

        // 6: reset during the data byte of a write of 0x00
        clear_frames();
        snap = rsp_cnt;
        do_req(1'b1, 4'h4, 8'h00);
        wait_frames(1, "t6_frames");
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t6_txd_low_before", {31'h0, uart_txd}, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("t6_txd_high", {31'h0, uart_txd}, 32'h1);
        check("t6_ready_rst", {31'h0, req_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (300) @(posedge clk);
        check("t6_no_rsp", rsp_cnt - snap, 32'h0);
        #1;
        clear_frames();
        do_req(1'b0, 4'h6, 8'h00);
        wait_frames(1, "t6_frames2");
        repeat (15) @(posedge clk);
        #1 send_byte(8'hC3);
        wait_rsp(200, found, rd, er, at, rdy);
        check("t6_cmd", frame_at(0), 32'h66);
        check("t6_found", {31'h0, found}, 32'h1);
        check("t6_rdata", {24'h0, rd}, 32'hC3);
        check("t6_error", {31'h0, er}, 32'h0);
        repeat (20) @(posedge clk);
        #1;

`ifdef UART_MASTER_WVERIFY_EN
        // Write 8 <- 0x5A, target echoes 0x5B on read-back
        clear_frames();
        do_req(1'b1, 4'h8, 8'h5A);
        wait_frames(3, "v_frames");
        repeat (15) @(posedge clk);
        #1 send_byte(8'h5B);
        wait_rsp(200, found, rd, er, at, rdy);
        check("v_f0", frame_at(0), 32'h48);
        check("v_f1", frame_at(1), 32'h5A);
        check("v_f2", frame_at(2), 32'h68);
        check("v_found", {31'h0, found}, 32'h1);
        check("v_error", {31'h0, er}, 32'h1);
        check("v_rdata", {24'h0, rd}, 32'h5B);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
